// File: rtl/plic_pkg.sv
// rtl/plic_pkg.sv - PLIC context/claim constants, types and address helpers
package plic_pkg;

  localparam int N_INTERRUPTS = 32;
  localparam int N_CONTEXTS   = 2;
  localparam int PRIO_WIDTH   = 3;
  localparam int ID_WIDTH     = $clog2(N_INTERRUPTS + 1);

  localparam logic [31:0] ENABLE_BASE    = 32'h0000_2000;
  localparam logic [31:0] CONTEXT_BASE   = 32'h0020_0000;
  localparam logic [31:0] THRESH_OFFSET  = 32'h0;
  localparam logic [31:0] CLAIM_OFFSET   = 32'h4;
  localparam logic [31:0] ENABLE_STRIDE  = 32'h80;
  localparam logic [31:0] CONTEXT_STRIDE = 32'h1000;

  // IDs 0..N_INTERRUPTS occupy N_INTERRUPTS+1 enable bits, rounded up to whole words
  localparam int N_EN_WORDS = (N_INTERRUPTS + 32) / 32;
  localparam int EN_BITS    = N_EN_WORDS * 32;

  typedef logic [PRIO_WIDTH-1:0] prio_t;
  typedef logic [ID_WIDTH-1:0]   irq_id_t;

  // Writable enable bits: ID 0 and IDs beyond N_INTERRUPTS stay 0
  function automatic logic [EN_BITS-1:0] id_mask();
    logic [EN_BITS-1:0] m;
    m = '0;
    for (int i = 1; i <= N_INTERRUPTS; i++) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [EN_BITS-1:0] ID_MASK = id_mask();

  function automatic logic [31:0] enable_addr(int c, int k);
    return ENABLE_BASE + 32'(c) * ENABLE_STRIDE + 32'(4 * k);
  endfunction

  function automatic logic [31:0] thresh_addr(int c);
    return CONTEXT_BASE + 32'(c) * CONTEXT_STRIDE + THRESH_OFFSET;
  endfunction

  function automatic logic [31:0] claim_addr(int c);
    return CONTEXT_BASE + 32'(c) * CONTEXT_STRIDE + CLAIM_OFFSET;
  endfunction

endpackage

// File: rtl/plic_priority_select.sv
// rtl/plic_priority_select.sv - max-priority, lowest-ID source selection for one context
module plic_priority_select
  import plic_pkg::*;
(
  input  logic [N_INTERRUPTS-1:0]            eligible_i,
  input  logic [N_INTERRUPTS*PRIO_WIDTH-1:0] priority_i,
  output irq_id_t                            best_id_o,
  output prio_t                              best_prio_o
);

  irq_id_t id_acc;
  prio_t   prio_acc;

  // Scan upward with strict compare so equal priorities keep the lower ID
  always_comb begin
    id_acc   = '0;
    prio_acc = '0;
    for (int i = 0; i < N_INTERRUPTS; i++) begin
      if (eligible_i[i] && (priority_i[i*PRIO_WIDTH +: PRIO_WIDTH] > prio_acc)) begin
        id_acc   = irq_id_t'(i + 1);
        prio_acc = priority_i[i*PRIO_WIDTH +: PRIO_WIDTH];
      end
    end
  end

  assign best_id_o   = id_acc;
  assign best_prio_o = prio_acc;

endmodule

// File: rtl/plic_context_claim_unit.sv
// rtl/plic_context_claim_unit.sv - per-context enables, thresholds, claim/complete and irq lines
module plic_context_claim_unit
  import plic_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_INTERRUPTS-1:0]            interrupt_pending,
  input  logic [N_INTERRUPTS*PRIO_WIDTH-1:0] interrupt_priority,
  output logic [N_INTERRUPTS-1:0]            claim_pulse,
  output logic [N_INTERRUPTS-1:0]            complete_pulse,
  output logic [N_CONTEXTS-1:0]              irq_out,
  input  logic [31:0]                        addr,
  input  logic                               wen,
  input  logic                               ren,
  input  logic [31:0]                        wdata,
  output logic [31:0]                        rdata,
  output logic                               addr_valid
);

  logic [N_CONTEXTS-1:0][EN_BITS-1:0]      enable_q, enable_d;
  prio_t                                   thresh_q [N_CONTEXTS];
  prio_t                                   thresh_d [N_CONTEXTS];
  logic [N_INTERRUPTS-1:0]                 in_service_q, in_service_d;
  irq_id_t                                 best_id_q [N_CONTEXTS];
  irq_id_t                                 best_id_d [N_CONTEXTS];
  prio_t                                   best_prio_q [N_CONTEXTS];
  prio_t                                   best_prio_d [N_CONTEXTS];
  logic [N_CONTEXTS-1:0][N_INTERRUPTS-1:0] eligible;

  // Bus decode, read mux, claim/complete pulses and register next-state
  always_comb begin
    rdata          = '0;
    addr_valid     = 1'b0;
    claim_pulse    = '0;
    complete_pulse = '0;
    enable_d       = enable_q;
    thresh_d       = thresh_q;
    in_service_d   = in_service_q;
    for (int c = 0; c < N_CONTEXTS; c++) begin
      for (int k = 0; k < N_EN_WORDS; k++) begin
        if (addr == enable_addr(c, k)) begin
          addr_valid = 1'b1;
          rdata      = enable_q[c][k*32 +: 32];
          if (wen) enable_d[c][k*32 +: 32] = wdata & ID_MASK[k*32 +: 32];
        end
      end
      if (addr == thresh_addr(c)) begin
        addr_valid = 1'b1;
        rdata      = 32'(thresh_q[c]);
        if (wen) thresh_d[c] = wdata[PRIO_WIDTH-1:0];
      end
      if (addr == claim_addr(c)) begin
        addr_valid = 1'b1;
        rdata      = 32'(best_id_q[c]);
        if (wen) begin
          // Complete: only an in-service source this context has enabled
          for (int i = 0; i < N_INTERRUPTS; i++) begin
            if ((wdata == 32'(i + 1)) && in_service_q[i] && enable_q[c][i+1]) begin
              complete_pulse[i] = 1'b1;
              in_service_d[i]   = 1'b0;
            end
          end
        end else if (ren) begin
          // Claim: best_id_q of 0 matches no source, so nothing happens
          for (int i = 0; i < N_INTERRUPTS; i++) begin
            if (best_id_q[c] == irq_id_t'(i + 1)) begin
              claim_pulse[i]  = 1'b1;
              in_service_d[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Eligibility; a source claimed this cycle is hidden from every context
  always_comb begin
    eligible = '0;
    for (int c = 0; c < N_CONTEXTS; c++) begin
      for (int i = 0; i < N_INTERRUPTS; i++) begin
        eligible[c][i] = interrupt_pending[i] & enable_q[c][i+1] & ~in_service_q[i]
                       & ~claim_pulse[i]
                       & (interrupt_priority[i*PRIO_WIDTH +: PRIO_WIDTH] > thresh_q[c]);
      end
    end
  end

  for (genvar c = 0; c < N_CONTEXTS; c++) begin : g_ctx
    plic_priority_select u_select (
      .eligible_i  (eligible[c]),
      .priority_i  (interrupt_priority),
      .best_id_o   (best_id_d[c]),
      .best_prio_o (best_prio_d[c])
    );
  end

  // A selected source always has nonzero priority, so this tracks best_id_q != 0
  always_comb begin
    irq_out = '0;
    for (int c = 0; c < N_CONTEXTS; c++) irq_out[c] = (best_prio_q[c] != '0);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q     <= '0;
      thresh_q     <= '{default: '0};
      in_service_q <= '0;
      best_id_q    <= '{default: '0};
      best_prio_q  <= '{default: '0};
    end else begin
      enable_q     <= enable_d;
      thresh_q     <= thresh_d;
      in_service_q <= in_service_d;
      best_id_q    <= best_id_d;
      best_prio_q  <= best_prio_d;
    end
  end

endmodule

// File: tb/tb_plic_context_claim_unit.sv
// tb/tb_plic_context_claim_unit.sv - directed scoreboard bench for plic_context_claim_unit
module tb_plic_context_claim_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pend = '0;
  logic [95:0] prio = '0;
  logic [31:0] claim_pulse, complete_pulse;
  logic [1:0]  irq_out;
  logic [31:0] addr = '0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        addr_valid;

  logic [31:0] obs_rdata, obs_claim, obs_comp;
  logic        obs_valid;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  plic_context_claim_unit dut (
    .clk                (clk),
    .rst                (rst),
    .interrupt_pending  (pend),
    .interrupt_priority (prio),
    .claim_pulse        (claim_pulse),
    .complete_pulse     (complete_pulse),
    .irq_out            (irq_out),
    .addr               (addr),
    .wen                (wen),
    .ren                (ren),
    .wdata              (wdata),
    .rdata              (rdata),
    .addr_valid         (addr_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] en_a(int c, int k);
    return 32'h2000 + 32'(c) * 32'h80 + 32'(4 * k);
  endfunction
  function automatic logic [31:0] th_a(int c);
    return 32'h20_0000 + 32'(c) * 32'h1000;
  endfunction
  function automatic logic [31:0] cl_a(int c);
    return 32'h20_0000 + 32'(c) * 32'h1000 + 32'h4;
  endfunction

  task automatic expect_val(string tag, logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_next(logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(int id, logic [2:0] p);
    prio[(id-1)*3 +: 3] = p;
  endtask

  task automatic bus(logic [31:0] a, logic w, logic r, logic [31:0] d);
    addr  = a;
    wen   = w;
    ren   = r;
    wdata = d;
    #2;
    obs_rdata = rdata;
    obs_valid = addr_valid;
    obs_claim = claim_pulse;
    obs_comp  = complete_pulse;
    @(posedge clk);
    #1;
    wen = 1'b0;
    ren = 1'b0;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    bus(a, 1'b1, 1'b0, d);
  endtask

  task automatic rd(string tag, logic [31:0] a, logic [31:0] exp, logic exp_valid);
    expect_val(tag, exp);
    expect_val({tag, "_valid"}, 32'(exp_valid));
    bus(a, 1'b0, 1'b1, '0);
    check_next(obs_rdata);
    check_next(32'(obs_valid));
  endtask

  task automatic claim(string tag, int c, int exp_id);
    expect_val({tag, "_id"}, 32'(exp_id));
    expect_val({tag, "_pulse"}, (exp_id == 0) ? 32'h0 : (32'h1 << (exp_id - 1)));
    bus(cl_a(c), 1'b0, 1'b1, '0);
    check_next(obs_rdata);
    check_next(obs_claim);
  endtask

  task automatic complete(string tag, int c, int id, logic [31:0] exp_pulse);
    expect_val(tag, exp_pulse);
    bus(cl_a(c), 1'b1, 1'b0, 32'(id));
    check_next(obs_comp);
  endtask

  task automatic check_irq(string tag, logic [1:0] exp);
    expect_val(tag, 32'(exp));
    check_next(32'(irq_out));
  endtask

  initial begin
    // Reset state
    #1;
    check_irq("reset_irq", 2'b00);
    expect_val("reset_claim_pulse", 32'h0);
    check_next(claim_pulse);
    expect_val("reset_complete_pulse", 32'h0);
    check_next(complete_pulse);
    tick();
    rst = 1'b0;
    rd("reset_thresh0", th_a(0), 32'h0, 1'b1);
    rd("reset_claim0", cl_a(0), 32'h0, 1'b1);

    // ID 5 prio 3 on ctx0: irq one cycle after pending rises
    set_prio(5, 3'd3);
    wr(en_a(0, 0), 32'h20);
    pend[4] = 1'b1;
    #1;
    check_irq("irq_before_edge", 2'b00);
    tick();
    check_irq("irq_ctx0_only", 2'b01);

    // Enable/threshold boundaries
    wr(en_a(0, 0), 32'hFFFF_FFFF);
    rd("en_word0_id0_masked", en_a(0, 0), 32'hFFFF_FFFE, 1'b1);
    wr(en_a(0, 1), 32'hFFFF_FFFF);
    rd("en_word1_only_id32", en_a(0, 1), 32'h1, 1'b1);
    wr(en_a(0, 1), 32'h0);
    wr(en_a(0, 0), 32'h20);
    wr(th_a(1), 32'hFFFF_FFFF);
    rd("thresh_truncated", th_a(1), 32'h7, 1'b1);
    wr(th_a(1), 32'h0);
    rd("unmapped_en_word2", en_a(0, 2), 32'h0, 1'b0);
    rd("unmapped_ctx2", en_a(2, 0), 32'h0, 1'b0);

    // Claim 5, bogus complete, real complete, re-arm
    claim("claim5", 0, 5);
    check_irq("irq_after_claim5", 2'b00);
    complete("complete9_ignored", 0, 9, 32'h0);
    complete("complete5", 0, 5, 32'h10);
    check_irq("irq_still_low", 2'b00);
    tick();
    check_irq("irq_rearm", 2'b01);
    pend = '0;
    wr(en_a(0, 0), 32'h0);
    tick();

    // Tie at prio 2: lower ID first
    set_prio(3, 3'd2);
    set_prio(7, 3'd2);
    wr(en_a(0, 0), 32'h88);
    pend[2] = 1'b1;
    pend[6] = 1'b1;
    tick();
    claim("claim_tie_low", 0, 3);
    claim("claim_tie_next", 0, 7);
    check_irq("irq_both_in_service", 2'b00);
    pend = '0;
    complete("complete3", 0, 3, 32'h4);
    complete("complete7", 0, 7, 32'h40);
    wr(en_a(0, 0), 32'h0);

    // Strict threshold compare
    set_prio(4, 3'd3);
    wr(th_a(0), 32'h3);
    wr(en_a(0, 0), 32'h10);
    pend[3] = 1'b1;
    tick();
    tick();
    check_irq("irq_prio_eq_thresh", 2'b00);
    wr(th_a(0), 32'h2);
    check_irq("irq_thresh_just_written", 2'b00);
    tick();
    check_irq("irq_prio_gt_thresh", 2'b01);
    pend = '0;
    wr(th_a(0), 32'h0);
    wr(en_a(0, 0), 32'h0);

    // ID 6 shared by both contexts
    set_prio(6, 3'd1);
    wr(en_a(0, 0), 32'h40);
    wr(en_a(1, 0), 32'h40);
    pend[5] = 1'b1;
    tick();
    check_irq("irq_shared", 2'b11);
    claim("claim6_ctx0", 0, 6);
    check_irq("irq_shared_drop", 2'b00);
    claim("claim_empty_ctx1", 1, 0);
    wr(en_a(1, 0), 32'h0);
    complete("complete6_ctx1_disabled", 1, 6, 32'h0);
    complete("complete6_ctx0", 0, 6, 32'h20);
    tick();
    check_irq("irq_6_back", 2'b01);

    // Write and read together: write only, no claim
    expect_val("wr_rd_claim_pulse", 32'h0);
    expect_val("wr_rd_complete_pulse", 32'h0);
    bus(cl_a(0), 1'b1, 1'b1, 32'h0);
    check_next(obs_claim);
    check_next(obs_comp);
    check_irq("irq_after_wr_rd", 2'b01);

    // Claim at t, complete at t+1, eligible again at t+2
    claim("claim6_back2back", 0, 6);
    complete("complete6_back2back", 0, 6, 32'h20);
    check_irq("irq_t1", 2'b00);
    tick();
    check_irq("irq_t2", 2'b01);

    // Reset while ID 6 is in service
    wr(th_a(1), 32'h5);
    claim("claim6_pre_reset", 0, 6);
    addr  = cl_a(0);
    wdata = 32'h6;
    wen   = 1'b1;
    rst   = 1'b1;
    #1;
    check_irq("irq_in_reset", 2'b00);
    expect_val("complete_in_reset", 32'h0);
    check_next(complete_pulse);
    wen = 1'b0;
    ren = 1'b1;
    #1;
    expect_val("claim_in_reset", 32'h0);
    check_next(claim_pulse);
    ren = 1'b0;
    tick();
    rd("thresh1_after_reset", th_a(1), 32'h0, 1'b1);
    rd("en0_after_reset", en_a(0, 0), 32'h0, 1'b1);
    rst = 1'b0;
    tick();
    check_irq("irq_after_reset_release", 2'b00);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
